// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } rx_state_t;

  // Parity selection encodings (2'b11 also means no parity)
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Shortest supported data field
  localparam int MIN_DATA_BITS = 5;

  // Clamp a requested data length into [MIN_DATA_BITS, max_bits]
  function automatic logic [3:0] clamp_bits(input logic [3:0] req,
                                            input logic [3:0] max_bits);
    logic [3:0] r;
    r = req;
    if (req < 4'(MIN_DATA_BITS)) r = 4'(MIN_DATA_BITS);
    else if (req > max_bits)     r = max_bits;
    return r;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Oversample counter and 3-sample majority voter. Produces a single-clk
// decision strobe and the voted bit value on the decision tick.
module uart_bit_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic os_tick,
  input  logic rx,
  input  logic run,       // counter runs only while a frame is in progress
  input  logic half_bit,  // decide at mid-start-bit instead of a full bit
  output logic decide,
  output logic bit_val
);

  localparam int CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] cnt;
  logic [1:0]    hist;
  logic [CW-1:0] decide_at;

  assign decide_at = half_bit ? CW'(OVERSAMPLE / 2 - 1) : CW'(OVERSAMPLE - 1);

  // The decision tick's own sample is the third vote, taken straight from rx
  assign decide  = run && os_tick && (cnt == decide_at);
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx) | (hist[0] & rx);

  // Sample history on every tick; os counter restarts after each decision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      hist <= '0;
    end else begin
      if (os_tick) hist <= {hist[0], rx};
      if (!run)
        cnt <= '0;
      else if (os_tick)
        cnt <= (cnt == decide_at) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable data length, parity and
// stop bits, break detection and a single-entry valid/ready output holder.
//
// Handshake: rx_valid high means rx_data, frame_error and parity_error are
// stable and owned by the consumer. A transfer happens on a rising clk edge
// where rx_valid and rx_ready are both high. rx_valid never drops without a
// transfer; a frame finishing while the holder is full and not being
// emptied is discarded and flagged with a one-clk overrun pulse.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 8,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_sync_in,
  input  logic                     os_tick,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     frame_error,
  output logic                     parity_error,
  output logic                     overrun,
  output logic                     break_detect,
  output logic                     busy,
  output logic [2:0]               state_dbg
);

  rx_state_t state, state_nxt;

  // Frame configuration captured at the start edge
  logic [3:0] lat_bits;
  logic [1:0] lat_par;
  logic       lat_stop2;
  logic       par_en;

  // Per-frame datapath
  logic [3:0]               bit_cnt;
  logic [MAX_DATA_BITS-1:0] shreg, shifted;
  logic                     par_acc;
  logic                     zero_so_far;
  logic                     stop_idx;
  logic                     ferr_acc;
  logic                     perr_acc;
  logic                     rx_prev;

  // FSM control strobes
  logic start_frame;
  logic complete;
  logic brk;

  // Sampler interface
  logic run, half_bit, decide, bit_val;

  assign par_en    = (lat_par == PAR_EVEN) || (lat_par == PAR_ODD);
  assign run       = (state == S_START) || (state == S_DATA) ||
                     (state == S_PARITY) || (state == S_STOP);
  assign half_bit  = (state == S_START);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  uart_bit_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk      (clk),
    .reset_n  (reset_n),
    .os_tick  (os_tick),
    .rx       (rx_sync_in),
    .run      (run),
    .half_bit (half_bit),
    .decide   (decide),
    .bit_val  (bit_val)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    complete    = 1'b0;
    brk         = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_sync_in) begin
          state_nxt   = S_START;
          start_frame = 1'b1;
        end
      end
      S_START: begin
        if (decide) state_nxt = bit_val ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide && (bit_cnt == lat_bits - 4'd1))
          state_nxt = par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (decide) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          if (!stop_idx && zero_so_far && !bit_val) begin
            brk       = 1'b1;
            state_nxt = S_BRK_WAIT;
          end else if (lat_stop2 && !stop_idx) begin
            state_nxt = S_STOP;
          end else begin
            complete  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_BRK_WAIT: begin
        if (rx_sync_in) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Insert the new data bit at the top of the configured field, LSB first
  always_comb begin
    shifted = shreg >> 1;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (4'(i) == lat_bits - 4'd1) shifted[i] = bit_val;
    end
  end

  // Frame datapath: config latch, shift register, parity and error tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_bits    <= '0;
      lat_par     <= '0;
      lat_stop2   <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_acc     <= 1'b0;
      zero_so_far <= 1'b0;
      stop_idx    <= 1'b0;
      ferr_acc    <= 1'b0;
      perr_acc    <= 1'b0;
      rx_prev     <= 1'b0;
    end else begin
      rx_prev <= rx_sync_in;
      if (start_frame) begin
        lat_bits    <= clamp_bits(cfg_data_bits, 4'(MAX_DATA_BITS));
        lat_par     <= cfg_parity;
        lat_stop2   <= cfg_stop2;
        bit_cnt     <= '0;
        shreg       <= '0;
        par_acc     <= 1'b0;
        zero_so_far <= 1'b1;
        stop_idx    <= 1'b0;
        ferr_acc    <= 1'b0;
        perr_acc    <= 1'b0;
      end else if (decide) begin
        case (state)
          S_DATA: begin
            shreg       <= shifted;
            par_acc     <= par_acc ^ bit_val;
            zero_so_far <= zero_so_far & ~bit_val;
            bit_cnt     <= bit_cnt + 4'd1;
          end
          S_PARITY: begin
            // Even: data ones plus parity bit must be even; odd: must be odd
            perr_acc    <= (par_acc ^ bit_val) ^ (lat_par == PAR_ODD);
            zero_so_far <= zero_so_far & ~bit_val;
          end
          S_STOP: begin
            stop_idx <= 1'b1;
            ferr_acc <= ferr_acc | ~bit_val;
          end
          default: ;
        endcase
      end
    end
  end

  // Output holder: load, drop-with-overrun, or release on transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
      break_detect <= 1'b0;
    end else begin
      overrun      <= 1'b0;
      break_detect <= brk;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data      <= shreg;
          frame_error  <= ferr_acc | ~bit_val;
          parity_error <= perr_acc;
          rx_valid     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed frames plus randomized frames checked
// against a frame-level reference model and an expected-word queue.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int MAXB     = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;
  localparam int W        = MAXB + 2;

  logic            clk;
  logic            reset_n;
  logic            rx_sync_in;
  logic            os_tick;
  logic [3:0]      cfg_data_bits;
  logic [1:0]      cfg_parity;
  logic            cfg_stop2;
  logic [MAXB-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            frame_error;
  logic            parity_error;
  logic            overrun;
  logic            break_detect;
  logic            busy;
  logic [2:0]      state_dbg;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ovr_seen = 0;
  int brk_seen = 0;
  int exp_ovr  = 0;
  int exp_brk  = 0;

  uart_rx_os #(
    .MAX_DATA_BITS (MAXB),
    .OVERSAMPLE    (OS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_sync_in    (rx_sync_in),
    .os_tick       (os_tick),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_error   (frame_error),
    .parity_error  (parity_error),
    .overrun       (overrun),
    .break_detect  (break_detect),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset / tick ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 os_tick = 1'b1;
      @(posedge clk);
      #1 os_tick = 1'b0;
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (overrun)      ovr_seen++;
      if (break_detect) brk_seen++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else check("rx_word", 32'({frame_error, parity_error, rx_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    rx_sync_in = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic [1:0] par,
                            input logic pbit, input logic st2, input logic s1, input logic s2);
    drive_bit(1'b0);
    // Configuration is captured at the start edge; scramble it afterwards
    cfg_data_bits = 4'($urandom_range(0, 15));
    cfg_parity    = 2'($urandom_range(0, 3));
    cfg_stop2     = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (par == 2'b01 || par == 2'b10) drive_bit(pbit);
    drive_bit(s1);
    if (st2) drive_bit(s2);
    rx_sync_in = 1'b1;
  endtask

  // Reference model: predicts the delivered word (or a break) from the
  // frame description, then drives the frame
  task automatic send_and_expect(input logic [7:0] d, input logic [3:0] cb, input logic [1:0] par,
                                 input logic pbit, input logic st2, input logic s1,
                                 input logic s2, input bit push);
    int n;
    int ones;
    logic [7:0] e;
    logic par_en, good_p, perr, ferr, is_brk;
    n = (cb < 4'd5) ? 5 : (cb > 4'(MAXB)) ? MAXB : int'(cb);
    e = '0;
    for (int i = 0; i < n; i++) e[i] = d[i];
    ones   = $countones(e);
    par_en = (par == 2'b01) || (par == 2'b10);
    good_p = (par == 2'b01) ? 1'(ones % 2) : 1'((ones + 1) % 2);
    perr   = par_en && (pbit != good_p);
    ferr   = !s1 || (st2 && !s2);
    is_brk = (e == 8'h00) && (!par_en || !pbit) && !s1;
    if (is_brk) exp_brk++;
    else if (push) exp_q.push_back({ferr, perr, e});
    cfg_data_bits = cb;
    cfg_parity    = par;
    cfg_stop2     = st2;
    send_frame(d, n, par, pbit, st2, s1, s2);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic [1:0] par;
    logic st2, s1, s2, pb;
    logic [3:0] cb;

    reset_n       = 1'b0;
    rx_sync_in    = 1'b1;
    rx_ready      = 1'b1;
    cfg_data_bits = 4'd8;
    cfg_parity    = PAR_NONE;
    cfg_stop2     = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_perr", 32'(parity_error), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_brk", 32'(break_detect), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    reset_n = 1'b1;
    drive_bit(1'b1);

    // 8N1 0xA5
    send_and_expect(8'hA5, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_drain(200);
    drive_bit(1'b1);

    // 7E2 0x3C with a wrong parity bit, held for inspection
    rx_ready = 1'b0;
    send_and_expect(8'h3C, 4'd7, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("7e2_valid", 32'(rx_valid), 32'd1);
    check("7e2_data", 32'(rx_data), 32'h3C);
    check("7e2_perr", 32'(parity_error), 32'd1);
    check("7e2_ferr", 32'(frame_error), 32'd0);
    rx_ready = 1'b1;
    wait_drain(50);
    drive_bit(1'b1);

    // 8N1 with a zero stop bit
    send_and_expect(8'h55, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain(200);
    drive_bit(1'b1);

    // Break: line low for start + 8 data + stop and beyond
    cfg_data_bits = 4'd8;
    cfg_parity    = PAR_NONE;
    cfg_stop2     = 1'b0;
    rx_sync_in    = 1'b0;
    exp_brk++;
    repeat (13 * BIT_CLKS) @(posedge clk);
    #1;
    check("brk_count", 32'(brk_seen), 32'(exp_brk));
    check("brk_state", 32'(state_dbg), 32'(S_BRK_WAIT));
    check("brk_busy", 32'(busy), 32'd1);
    check("brk_novalid", 32'(rx_valid), 32'd0);
    rx_sync_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("brk_release", 32'(busy), 32'd0);
    drive_bit(1'b1);

    // 4-tick glitch: false start
    rx_sync_in = 1'b0;
    repeat (4 * TICK_DIV) @(posedge clk);
    #1;
    check("glitch_busy", 32'(busy), 32'd1);
    rx_sync_in = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_novalid", 32'(rx_valid), 32'd0);

    // Overrun: two frames with the consumer stalled
    rx_ready = 1'b0;
    send_and_expect(8'h11, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b1);
    exp_ovr++;
    send_and_expect(8'h22, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_count", 32'(ovr_seen), 32'(exp_ovr));
    rx_ready = 1'b1;
    wait_drain(50);
    check("ovr_cleared", 32'(rx_valid), 32'd0);
    drive_bit(1'b1);

    // Reset mid-DATA with a word held
    rx_ready = 1'b0;
    send_and_expect(8'h77, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b1);
    check("hold_data", 32'(rx_data), 32'h77);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mrst_valid", 32'(rx_valid), 32'd0);
    check("mrst_data", 32'(rx_data), 32'd0);
    check("mrst_ferr", 32'(frame_error), 32'd0);
    check("mrst_perr", 32'(parity_error), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_state", 32'(state_dbg), 32'(S_IDLE));
    rx_sync_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    rx_ready = 1'b1;
    drive_bit(1'b1);
    send_and_expect(8'h5A, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_drain(200);
    drive_bit(1'b1);

    // Randomized frames, consumer always ready, no breaks
    for (int f = 0; f < 24; f++) begin
      d   = 8'($urandom);
      cb  = 4'($urandom_range(0, 15));
      par = 2'($urandom_range(0, 3));
      pb  = 1'($urandom_range(0, 1));
      st2 = 1'($urandom_range(0, 1));
      s1  = ($urandom_range(0, 4) != 0);
      s2  = ($urandom_range(0, 4) != 0);
      if (!s1) d[0] = 1'b1;
      send_and_expect(d, cb, par, pb, st2, s1, s2, 1'b1);
      wait_drain(200);
      repeat ($urandom_range(1, 2)) drive_bit(1'b1);
    end

    check("total_ovr", 32'(ovr_seen), 32'(exp_ovr));
    check("total_brk", 32'(brk_seen), 32'(exp_brk));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
